icache_param: RTL and testbench



---
 rtl/icache_param.sv | 132 +++++++++++++
 tb/tb_icache_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_param.sv
// Parametrised direct-mapped instruction cache with burst line fill and flush.
// Optional hit/miss statistics counters are enabled with `define ICACHE_STATS_EN.
module icache_param #(
  parameter int NSETS    = 8,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt
`endif
);
  localparam int IW = $clog2(NSETS);
  localparam int OW = $clog2(BLKWORDS);
  localparam int TW = 30 - IW - OW;
  // counter/offset keep one bit when a block is a single word; held at 0 then
  localparam int CW = (OW > 0) ? OW : 1;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, next_state;

  logic [NSETS-1:0] valid;
  logic [TW-1:0]    tags [NSETS];
  logic [31:0]      data [NSETS][BLKWORDS];

  logic [TW-1:0] atag, ftag;
  logic [IW-1:0] aidx, fidx;
  logic [CW-1:0] woff, cnt;
  logic          hit, start, wr, last;

  assign atag = imemaddr[31:32-TW];
  assign aidx = imemaddr[IW+OW+1:OW+2];

  generate
    if (OW > 0) begin : g_woff
      assign woff = imemaddr[OW+1:2];
    end else begin : g_no_woff
      assign woff = '0;
    end
  endgenerate

  assign hit      = imemREN & valid[aidx] & (tags[aidx] == atag);
  assign imemload = data[aidx][woff];
  assign last     = (cnt == CW'(BLKWORDS - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    wr         = 1'b0;
    ihit       = 1'b0;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state)
      IDLE: begin
        ihit = hit & ~dmemREN & ~dmemWEN & ~iflush;
        if (imemREN && !hit && !iflush) begin
          start      = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {ftag, fidx, {(OW + 2){1'b0}}} | (32'(cnt) << 2);
        if (!iwait && !iflush) begin
          wr = 1'b1;
          if (last) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (iflush) next_state = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      ftag  <= '0;
      fidx  <= '0;
      cnt   <= '0;
      for (int s = 0; s < NSETS; s++) begin
        tags[s] <= '0;
        for (int w = 0; w < BLKWORDS; w++) data[s][w] <= '0;
      end
    end else if (iflush) begin
      valid <= '0;
    end else if (start) begin
      ftag        <= atag;
      fidx        <= aidx;
      cnt         <= '0;
      valid[aidx] <= 1'b0;
    end else if (wr) begin
      data[fidx][cnt] <= iload;
      if (last) begin
        tags[fidx]  <= ftag;
        valid[fidx] <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // saturating counters; deliberately untouched by iflush
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitcnt  <= '0;
      misscnt <= '0;
    end else begin
      if (ihit && hitcnt != '1)   hitcnt  <= hitcnt + 32'd1;
      if (start && misscnt != '1) misscnt <= misscnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_param.sv
// Self-checking bench for icache_param: directed scenarios plus randomized fetches
// against a set/tag/word reference model. Define ICACHE_STATS_EN to cover the counters.
module tb_icache_param;
  localparam int NS = 8;
  localparam int BW = 2;
  localparam int LINE_BYTES = 4 * BW;

  logic CLK = 1'b0;
  logic nRST, imemREN, dmemREN, dmemWEN, iflush, iwait;
  logic [31:0] imemaddr, iload;
  logic ihit, iREN;
  logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hitcnt, misscnt;
`endif

  icache_param #(.NSETS(NS), .BLKWORDS(BW)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hitcnt(hitcnt), .misscnt(misscnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int m_hits = 0;
  int m_misses = 0;
  bit          m_valid [NS];
  int          m_tag   [NS];
  logic [31:0] m_data  [NS][BW];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hAAAA_0000;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % NS);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'(a / (LINE_BYTES * NS));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % BW);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 1'b0;
      m_tag[s] = 0;
      for (int w = 0; w < BW; w++) m_data[s][w] = '0;
    end
  endtask

  // Starts and ends at posedge+1; stall_n cycles of iwait are forced on word stall_w.
  task automatic do_fetch(input logic [31:0] a, input int waitpct,
                          input int stall_w, input int stall_n);
    int s, t, wo, w, stalled, guard;
    bit exp_hit;
    logic [31:0] base, wa;
    s = set_of(a); t = tag_of(a); wo = word_of(a);
    base = a - (a % LINE_BYTES);
    imemREN = 1'b1; imemaddr = a; dmemREN = 1'b0; dmemWEN = 1'b0;
    iflush = 1'b0; iwait = 1'b0; iload = '0;
    @(negedge CLK);
    exp_hit = m_valid[s] && (m_tag[s] == t);
    chk("ihit_lookup", ihit, exp_hit);
    chk("imemload_lookup", imemload, m_data[s][wo]);
    chk("iREN_idle", iREN, 0);
    if (exp_hit) begin
      m_hits++;
    end else begin
      m_valid[s] = 1'b0;
      m_misses++;
      @(posedge CLK); #1;
      w = 0; stalled = 0; guard = 0;
      while (w < BW && guard < 200) begin
        guard++;
        wa = base + 32'(w * 4);
        if (w == stall_w && stalled < stall_n) begin
          iwait = 1'b1; stalled++;
        end else begin
          iwait = ($urandom_range(99) < waitpct);
        end
        iload = iwait ? $urandom : memfn(wa);
        imemREN = $urandom_range(1);
        imemaddr = {$urandom_range(255), 2'b00};
        @(negedge CLK);
        chk("iREN_fill", iREN, 1);
        chk("iaddr_fill", iaddr, wa);
        chk("ihit_fill", ihit, 0);
        if (!iwait) begin
          m_data[s][w] = memfn(wa);
          w++;
        end
        @(posedge CLK); #1;
      end
      if (guard >= 200) begin
        errors++;
        $error("FAIL fill_budget observed=%0d expected<200", guard);
      end
      m_valid[s] = 1'b1; m_tag[s] = t;
      imemREN = 1'b1; imemaddr = a; iwait = 1'b0; iload = '0;
      @(negedge CLK);
      chk("ihit_refill", ihit, 1);
      chk("imemload_refill", imemload, m_data[s][wo]);
      chk("iREN_after_fill", iREN, 0);
      chk("iaddr_after_fill", iaddr, 0);
      m_hits++;
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  task automatic do_flush();
    iflush = 1'b1; imemREN = 1'b1; imemaddr = {$urandom_range(63), 2'b00};
    @(negedge CLK);
    chk("ihit_during_flush", ihit, 0);
    @(posedge CLK); #1;
    iflush = 1'b0; imemREN = 1'b0;
    for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
  endtask

  initial begin
    int s;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; dmemREN = 1'b0; dmemWEN = 1'b0;
    iflush = 1'b0; iwait = 1'b0; iload = '0;
    model_reset();
    #12;
    chk("rst_ihit", ihit, 0);
    chk("rst_iREN", iREN, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_imemload", imemload, 0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // cold miss then same-line hit
    do_fetch(32'h40, 0, -1, 0);
    do_fetch(32'h44, 0, -1, 0);
    // conflict eviction on set 0
    do_fetch(32'h80, 0, -1, 0);
    do_fetch(32'h40, 0, -1, 0);
    // memory stall on word 1
    do_fetch(32'h140, 0, 1, 3);
    do_fetch(32'h48, 0, -1, 0);

    // hit suppression by a data access, released within the same cycle
    imemREN = 1'b1; imemaddr = 32'h144; dmemWEN = 1'b1;
    @(negedge CLK);
    chk("ihit_dmemWEN", ihit, 0);
    chk("imemload_dmemWEN", imemload, memfn(32'h144));
    dmemWEN = 1'b0;
    #1;
    chk("ihit_dmemWEN_drop", ihit, 1);
    m_hits++;
    @(posedge CLK); #1;
    dmemREN = 1'b1;
    @(negedge CLK);
    chk("ihit_dmemREN", ihit, 0);
    @(posedge CLK); #1;
    dmemREN = 1'b0; imemREN = 1'b0;

    // flush abandons a partial fill of 0x100
    s = set_of(32'h100);
    imemREN = 1'b1; imemaddr = 32'h100;
    @(negedge CLK);
    chk("ihit_0x100", ihit, 0);
    m_valid[s] = 1'b0; m_misses++;
    @(posedge CLK); #1;
    iwait = 1'b0; iload = memfn(32'h100);
    @(negedge CLK);
    chk("iaddr_0x100_w0", iaddr, 32'h100);
    @(posedge CLK); #1;
    m_data[s][0] = memfn(32'h100);
    iflush = 1'b1; iwait = 1'b1; iload = $urandom;
    @(negedge CLK);
    chk("iREN_flush_cycle", iREN, 1);
    chk("iaddr_0x100_w1", iaddr, 32'h104);
    @(posedge CLK); #1;
    iflush = 1'b0; iwait = 1'b0; imemREN = 1'b0;
    for (int k = 0; k < NS; k++) m_valid[k] = 1'b0;
    @(negedge CLK);
    chk("iREN_after_flush", iREN, 0);
    chk("iaddr_after_flush", iaddr, 0);
    chk("imemload_partial", imemload, m_data[s][0]);
    @(posedge CLK); #1;
    do_fetch(32'h100, 0, -1, 0);
    do_fetch(32'h48, 0, -1, 0);

    // randomized fetch mix with stalls and occasional flushes
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(9) == 0) do_flush();
      else do_fetch({$urandom_range(63), 2'b00}, 30, -1, 0);
    end

`ifdef ICACHE_STATS_EN
    chk("hitcnt", hitcnt, m_hits);
    chk("misscnt", misscnt, m_misses);
    do_flush();
    chk("hitcnt_after_flush", hitcnt, m_hits);
    chk("misscnt_after_flush", misscnt, m_misses);
`endif

    // async reset in the middle of a fill
    do_flush();
    imemREN = 1'b1; imemaddr = 32'h200;
    @(posedge CLK); #1;
    iwait = 1'b1;
    @(negedge CLK);
    chk("iREN_pre_reset", iREN, 1);
    #2 nRST = 1'b0;
    #1;
    chk("iREN_async_reset", iREN, 0);
    chk("iaddr_async_reset", iaddr, 0);
    chk("imemload_async_reset", imemload, 0);
`ifdef ICACHE_STATS_EN
    chk("hitcnt_reset", hitcnt, 0);
    chk("misscnt_reset", misscnt, 0);
`endif
    model_reset();
    imemREN = 1'b0; iwait = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    do_fetch(32'h40, 0, -1, 0);
    do_fetch(32'h44, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
